// File: rtl/deconv_col_feeder_pkg.sv
// Shared types and sizing helpers for the deconvolution column feeder.
package deconv_col_feeder_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_LOADW,
    ST_STREAM,
    ST_WAIT
  } state_e;

  function automatic int col_w(input int bit_width, input int n_pix);
    return bit_width * n_pix;
  endfunction

  // Index width that stays legal (>= 1 bit) for single-entry sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int N_CHANNEL_DEFAULT = 4;
  localparam int CHAN_W = idx_w(N_CHANNEL_DEFAULT);

endpackage

// File: rtl/deconv_col_feeder_buf.sv
// Column buffer: write-indexed register array with an asynchronous read port.
module deconv_col_buf
  import deconv_col_feeder_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int WIDTH = 40,
  localparam int AW = idx_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Contents survive channel changes; only the fill counts are reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/deconv_col_feeder.sv
// Buffers one weight channel and one feature channel, then replays every
// weight column against all feature columns under control of the core.
module deconv_col_feeder
  import deconv_col_feeder_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int WEIGHT_SIZE  = 5,
  parameter int FEATURE_SIZE = 8,
  parameter int N_CHANNEL    = 4,
  localparam int WCOL_W = col_w(BIT_WIDTH, WEIGHT_SIZE),
  localparam int FCOL_W = col_w(BIT_WIDTH, FEATURE_SIZE),
  localparam int CH_W   = idx_w(N_CHANNEL)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WCOL_W-1:0] i_w_data,
  input  logic              i_w_valid,
  output logic              o_w_ready,
  input  logic [FCOL_W-1:0] i_f_data,
  input  logic              i_f_valid,
  output logic              o_f_ready,
  output logic [WCOL_W-1:0] o_weight_col,
  output logic [FCOL_W-1:0] o_feature_map_col,
  output logic              o_enable_loadw,
  output logic              o_enable_loadip,
  input  logic              i_en_fifo_loop,
  input  logic              i_en_prcs_new_chnl,
  input  logic              i_en_prcs_new_wcoln,
  output logic [CH_W-1:0]   o_chan_idx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int WI_W = idx_w(WEIGHT_SIZE);
  localparam int FI_W = idx_w(FEATURE_SIZE);
  localparam int WC_W = cnt_w(WEIGHT_SIZE);
  localparam int FC_W = cnt_w(FEATURE_SIZE);

  localparam logic [WC_W-1:0] W_FULL = WC_W'(WEIGHT_SIZE);
  localparam logic [FC_W-1:0] F_FULL = FC_W'(FEATURE_SIZE);
  localparam logic [WI_W-1:0] W_LAST = WI_W'(WEIGHT_SIZE - 1);
  localparam logic [FI_W-1:0] F_LAST = FI_W'(FEATURE_SIZE - 1);
  localparam logic [CH_W-1:0] C_LAST = CH_W'(N_CHANNEL - 1);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [WI_W-1:0]   wcol_q, wcol_d;
  logic [FI_W-1:0]   fcol_q, fcol_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              loadw_q, loadw_d;
  logic              loadip_q, loadip_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [WCOL_W-1:0] wdata_q, wdata_d;
  logic [FCOL_W-1:0] fdata_q, fdata_d;

  logic              w_acc, f_acc, chan_end;
  logic [WI_W-1:0]   w_raddr;
  logic [FI_W-1:0]   f_raddr;
  logic [WCOL_W-1:0] w_rdata;
  logic [FCOL_W-1:0] f_rdata;

  assign o_w_ready = (state_q == ST_FILL) && (wcnt_q < W_FULL);
  assign o_f_ready = (state_q == ST_FILL) && (fcnt_q < F_FULL);
  assign w_acc     = i_w_valid && o_w_ready;
  assign f_acc     = i_f_valid && o_f_ready;

  deconv_col_buf #(.DEPTH(WEIGHT_SIZE), .WIDTH(WCOL_W)) u_wbuf (
    .i_clk   (i_clk),
    .i_we    (w_acc),
    .i_waddr (wcnt_q[WI_W-1:0]),
    .i_wdata (i_w_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  deconv_col_buf #(.DEPTH(FEATURE_SIZE), .WIDTH(FCOL_W)) u_fbuf (
    .i_clk   (i_clk),
    .i_we    (f_acc),
    .i_waddr (fcnt_q[FI_W-1:0]),
    .i_wdata (i_f_data),
    .i_raddr (f_raddr),
    .o_rdata (f_rdata)
  );

  // Read addresses look one column ahead so the column lands in the output
  // register on the same edge as the state that presents it.
  always_comb begin
    w_raddr = wcol_q;
    if (state_q == ST_WAIT && !i_en_prcs_new_chnl && i_en_prcs_new_wcoln) begin
      w_raddr = wcol_q + 1'b1;
    end
    f_raddr = '0;
    if (state_q == ST_STREAM) begin
      f_raddr = fcol_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    fcnt_d   = fcnt_q;
    wcol_d   = wcol_q;
    fcol_d   = fcol_q;
    chan_d   = chan_q;
    wdata_d  = wdata_q;
    fdata_d  = fdata_q;
    loadw_d  = 1'b0;
    loadip_d = 1'b0;
    done_d   = 1'b0;
    chan_end = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (w_acc) wcnt_d = wcnt_q + 1'b1;
        if (f_acc) fcnt_d = fcnt_q + 1'b1;
        if (wcnt_d == W_FULL && fcnt_d == F_FULL) begin
          state_d = ST_LOADW;
          wcol_d  = '0;
          loadw_d = 1'b1;
          wdata_d = w_rdata;
        end
      end
      ST_LOADW: begin
        if (i_en_prcs_new_chnl) begin
          chan_end = 1'b1;
        end else begin
          state_d  = ST_STREAM;
          fcol_d   = '0;
          loadip_d = 1'b1;
          fdata_d  = f_rdata;
        end
      end
      ST_STREAM: begin
        if (i_en_prcs_new_chnl) begin
          chan_end = 1'b1;
        end else if (fcol_q == F_LAST) begin
          state_d = ST_WAIT;
        end else begin
          fcol_d   = fcol_q + 1'b1;
          loadip_d = 1'b1;
          fdata_d  = f_rdata;
        end
      end
      ST_WAIT: begin
        if (i_en_prcs_new_chnl) begin
          chan_end = 1'b1;
        end else if (i_en_prcs_new_wcoln) begin
          if (wcol_q == W_LAST) begin
            chan_end = 1'b1;
          end else begin
            state_d = ST_LOADW;
            wcol_d  = wcol_q + 1'b1;
            loadw_d = 1'b1;
            wdata_d = w_rdata;
          end
        end else if (i_en_fifo_loop) begin
          state_d = ST_LOADW;
          loadw_d = 1'b1;
          wdata_d = w_rdata;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (chan_end) begin
      state_d = ST_FILL;
      wcnt_d  = '0;
      fcnt_d  = '0;
      wcol_d  = '0;
      fcol_d  = '0;
      if (chan_q == C_LAST) begin
        chan_d = '0;
        done_d = 1'b1;
      end else begin
        chan_d = chan_q + 1'b1;
      end
    end

    busy_d = (state_d != ST_FILL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_FILL;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      wcol_q   <= '0;
      fcol_q   <= '0;
      chan_q   <= '0;
      loadw_q  <= 1'b0;
      loadip_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      wdata_q  <= '0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      fcnt_q   <= fcnt_d;
      wcol_q   <= wcol_d;
      fcol_q   <= fcol_d;
      chan_q   <= chan_d;
      loadw_q  <= loadw_d;
      loadip_q <= loadip_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wdata_q  <= wdata_d;
      fdata_q  <= fdata_d;
    end
  end

  assign o_weight_col      = wdata_q;
  assign o_feature_map_col = fdata_q;
  assign o_enable_loadw    = loadw_q;
  assign o_enable_loadip   = loadip_q;
  assign o_chan_idx        = chan_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

endmodule

// File: tb/tb_deconv_col_feeder.sv
// Bench for deconv_col_feeder: directed request table, hand-written corner
// sequences, then randomized jobs against a column-sequence reference model.
module tb_deconv_col_feeder;

  localparam int WS = 5;
  localparam int FS = 8;
  localparam int NC = 2;

  logic        clk, rst;
  logic [39:0] w_data;
  logic        w_valid, w_ready;
  logic [63:0] f_data;
  logic        f_valid, f_ready;
  logic [39:0] weight_col;
  logic [63:0] fmap_col;
  logic        loadw, loadip;
  logic        loop, new_chnl, wcoln;
  logic [0:0]  chan_idx;
  logic        busy, done;

  deconv_col_feeder #(
    .BIT_WIDTH(8), .WEIGHT_SIZE(WS), .FEATURE_SIZE(FS), .N_CHANNEL(NC)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_w_data            (w_data),
    .i_w_valid           (w_valid),
    .o_w_ready           (w_ready),
    .i_f_data            (f_data),
    .i_f_valid           (f_valid),
    .o_f_ready           (f_ready),
    .o_weight_col        (weight_col),
    .o_feature_map_col   (fmap_col),
    .o_enable_loadw      (loadw),
    .o_enable_loadip     (loadip),
    .i_en_fifo_loop      (loop),
    .i_en_prcs_new_chnl  (new_chnl),
    .i_en_prcs_new_wcoln (wcoln),
    .o_chan_idx          (chan_idx),
    .o_busy              (busy),
    .o_done              (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no $finish, expected end of test");
    $fatal(1);
  end

  int n_tests;
  int n_fail;
  int model_chan;
  logic [39:0] wb [WS];
  logic [63:0] fb [FS];

  typedef struct {
    bit         chnl;
    bit         wcoln;
    bit         loop;
    int         exp_wcol;   // -1: channel end expected
    int         exp_chan;
    bit         exp_done;
    logic [7:0] base;       // pattern for the refill after a channel end
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input logic [7:0] base);
    for (int k = 0; k < WS; k++) wb[k] = {5{base + 8'(k) + 8'd1}};
    for (int j = 0; j < FS; j++) fb[j] = {8{base + 8'h10 + 8'(j)}};
  endtask

  // Uploads wb/fb; returns at the cycle following the last accepted beat.
  task automatic fill(input bit rnd);
    int wi, fi, guard;
    bit wa, fa;
    wi = 0; fi = 0; guard = 0;
    while ((wi < WS || fi < FS) && guard < 400) begin
      w_valid  = (wi < WS) && (!rnd || ($urandom_range(0, 2) != 0));
      f_valid  = (fi < FS) && (!rnd || ($urandom_range(0, 2) != 0));
      w_data   = wb[(wi < WS) ? wi : 0];
      f_data   = fb[(fi < FS) ? fi : 0];
      new_chnl = rnd && ($urandom_range(0, 1) == 1);
      check("w_ready", 64'(w_ready), 64'(wi < WS));
      check("f_ready", 64'(f_ready), 64'(fi < FS));
      wa = w_valid && w_ready;
      fa = f_valid && f_ready;
      tick();
      if (wa) wi++;
      if (fa) fi++;
      guard++;
    end
    w_valid = 1'b0; f_valid = 1'b0; new_chnl = 1'b0;
    check("fill_timeout", 64'(guard >= 400), 64'(0));
  endtask

  task automatic request(input bit c, input bit w, input bit l);
    new_chnl = c; wcoln = w; loop = l;
    tick();
    new_chnl = 1'b0; wcoln = 1'b0; loop = 1'b0;
  endtask

  // Called in the loadw cycle: one weight column, then all feature columns.
  task automatic expect_col(input int wc, input bit noise);
    check("loadw", 64'(loadw), 64'(1));
    check("weight_col", 64'(weight_col), 64'(wb[wc]));
    check("loadip_in_loadw", 64'(loadip), 64'(0));
    check("busy", 64'(busy), 64'(1));
    check("chan_idx", 64'(chan_idx), 64'(model_chan));
    for (int j = 0; j < FS; j++) begin
      if (noise) begin
        wcoln = 1'($urandom); loop = 1'($urandom);
      end
      tick();
      check("loadip", 64'(loadip), 64'(1));
      check("fmap_col", fmap_col, fb[j]);
      check("loadw_in_stream", 64'(loadw), 64'(0));
    end
    if (noise) begin
      wcoln = 1'($urandom); loop = 1'($urandom);
    end
    tick();
    wcoln = 1'b0; loop = 1'b0;
    check("wait_loadip", 64'(loadip), 64'(0));
    check("wait_loadw", 64'(loadw), 64'(0));
    check("wait_busy", 64'(busy), 64'(1));
    check("wcol_hold", 64'(weight_col), 64'(wb[wc]));
  endtask

  task automatic chan_end_check(input int exp_chan, input bit exp_done);
    check("end_loadw", 64'(loadw), 64'(0));
    check("end_loadip", 64'(loadip), 64'(0));
    check("end_busy", 64'(busy), 64'(0));
    check("end_chan", 64'(chan_idx), 64'(exp_chan));
    check("end_done", 64'(done), 64'(exp_done));
    check("end_w_ready", 64'(w_ready), 64'(1));
    check("end_f_ready", 64'(f_ready), 64'(1));
    model_chan = exp_chan;
    tick();
    check("done_once", 64'(done), 64'(0));
  endtask

  // Replay column 0, then request a new channel while fcol = 3 is shown.
  task automatic stream_abort(input int exp_chan, input bit exp_done);
    request(1'b0, 1'b0, 1'b1);
    check("abort_loadw", 64'(loadw), 64'(1));
    check("abort_wcol", 64'(weight_col), 64'(wb[0]));
    for (int j = 0; j < 4; j++) begin
      tick();
      check("abort_fmap", fmap_col, fb[j]);
    end
    new_chnl = 1'b1;
    tick();
    new_chnl = 1'b0;
    chan_end_check(exp_chan, exp_done);
  endtask

  int wcol, r, acts;
  bit ended;

  initial begin
    n_tests = 0; n_fail = 0; model_chan = 0;
    rst = 1'b1;
    w_valid = 1'b0; f_valid = 1'b0; w_data = '0; f_data = '0;
    loop = 1'b0; new_chnl = 1'b0; wcoln = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b1,  0, 0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b1,  1, 0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b0,  2, 0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 1'b1,  2, 0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 1'b0,  3, 0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b0,  4, 0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b0, -1, 1, 1'b0, 8'h40};
    vecs[7] = '{1'b0, 1'b1, 1'b0,  1, 1, 1'b0, 8'h00};
    vecs[8] = '{1'b1, 1'b1, 1'b1, -1, 0, 1'b1, 8'h80};

    repeat (3) @(posedge clk);
    #1;
    check("rst_loadw", 64'(loadw), 64'(0));
    check("rst_loadip", 64'(loadip), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_chan", 64'(chan_idx), 64'(0));
    check("rst_wcol", 64'(weight_col), 64'(0));
    check("rst_fmap", fmap_col, 64'(0));
    check("rst_w_ready", 64'(w_ready), 64'(1));
    check("rst_f_ready", 64'(f_ready), 64'(1));
    rst = 1'b0;
    tick();

    load_pattern(8'h00);
    fill(1'b0);
    check("first_wcol", 64'(weight_col), 64'h0101010101);
    expect_col(0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      request(vecs[i].chnl, vecs[i].wcoln, vecs[i].loop);
      if (vecs[i].exp_wcol < 0) begin
        chan_end_check(vecs[i].exp_chan, vecs[i].exp_done);
        load_pattern(vecs[i].base);
        fill(1'b0);
        expect_col(0, 1'b0);
      end else begin
        expect_col(vecs[i].exp_wcol, 1'b0);
      end
    end

    stream_abort(1, 1'b0);
    load_pattern(8'hC0);
    fill(1'b0);
    expect_col(0, 1'b0);
    repeat (3) begin
      tick();
      check("idle_no_loadw", 64'(loadw), 64'(0));
    end
    stream_abort(0, 1'b1);

    // Randomized jobs: model is the ordered list of columns the spec implies.
    for (int job = 0; job < 3; job++) begin
      for (int ch = 0; ch < NC; ch++) begin
        for (int k = 0; k < WS; k++) wb[k] = 40'({$urandom(), $urandom()});
        for (int j = 0; j < FS; j++) fb[j] = {$urandom(), $urandom()};
        fill(1'b1);
        expect_col(0, 1'b1);
        wcol = 0; ended = 1'b0; acts = 0;
        while (!ended) begin
          repeat ($urandom_range(0, 2)) begin
            tick();
            check("rnd_idle", 64'(loadw), 64'(0));
          end
          r = $urandom_range(0, 9);
          if (acts > 30) r = 0;
          acts++;
          if (r == 0) begin
            request(1'b1, 1'($urandom), 1'($urandom));
            ended = 1'b1;
          end else if (r < 4) begin
            request(1'b0, 1'b0, 1'b1);
            expect_col(wcol, 1'b1);
          end else begin
            request(1'b0, 1'b1, 1'($urandom));
            if (wcol < WS - 1) begin
              wcol++;
              expect_col(wcol, 1'b1);
            end else begin
              ended = 1'b1;
            end
          end
        end
        chan_end_check((model_chan + 1) % NC, model_chan == NC - 1);
      end
    end

    // Asynchronous reset in the middle of a stream.
    load_pattern(8'h20);
    fill(1'b0);
    check("pre_rst_loadw", 64'(loadw), 64'(1));
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_loadip", 64'(loadip), 64'(0));
    check("midrst_loadw", 64'(loadw), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_fmap", fmap_col, 64'(0));
    check("midrst_w_ready", 64'(w_ready), 64'(1));
    check("midrst_chan", 64'(chan_idx), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_chan = 0;
    tick();
    check("postrst_loadw", 64'(loadw), 64'(0));
    load_pattern(8'h50);
    fill(1'b0);
    expect_col(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deconv_col_feeder.md
# deconv_col_feeder

Column feeder on the transmit side of the deconvolution column interface. Buffers one kernel channel (WEIGHT_SIZE weight columns) and one input channel (FEATURE_SIZE feature-map columns) from upstream, then drives the load strobes and column buses of `deconv_op_top`. It reacts to the core's loopback, new-channel and new-weight-column requests, sequencing every weight column against all feature columns for N_CHANNEL channels.

## Interface
- BIT_WIDTH, 8, bits per pixel
- WEIGHT_SIZE, 5, pixels per weight column; weight columns per channel
- FEATURE_SIZE, 8, pixels per feature column; feature columns per channel
- N_CHANNEL, 4, channels per job
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_w_data  in  BIT_WIDTH*WEIGHT_SIZE  upstream weight column
- i_w_valid / o_w_ready  in/out  1  weight upload handshake
- i_f_data  in  BIT_WIDTH*FEATURE_SIZE  upstream feature column
- i_f_valid / o_f_ready  in/out  1  feature upload handshake
- o_weight_col  out  BIT_WIDTH*WEIGHT_SIZE  to core i_weight_col
- o_feature_map_col  out  BIT_WIDTH*FEATURE_SIZE  to core i_feature_map_col
- o_enable_loadw  out  1  one-cycle weight-column load pulse
- o_enable_loadip  out  1  feature-column load strobe
- i_en_fifo_loop  in  1  core requests replay of current weight column
- i_en_prcs_new_chnl  in  1  core requests jump to next channel
- i_en_prcs_new_wcoln  in  1  core finished current weight column
- o_chan_idx  out  $clog2(N_CHANNEL)  current channel
- o_busy  out  1  high outside FILL
- o_done  out  1  one-cycle pulse when last channel completes

## Operation
- States: FILL, LOADW, STREAM, WAIT. Counters: wcnt (buffered weight cols), fcnt (buffered feature cols), wcol, fcol, chan.
- FILL: o_w_ready = (wcnt < WEIGHT_SIZE), o_f_ready = (fcnt < FEATURE_SIZE); beat accepted on valid&ready, written at wbuf[wcnt] / fbuf[fcnt]. Both full -> LOADW, wcol=0.
- LOADW (1 cycle): o_enable_loadw=1, o_weight_col=wbuf[wcol], fcol=0 -> STREAM.
- STREAM (FEATURE_SIZE cycles): o_enable_loadip=1, o_feature_map_col=fbuf[fcol], fcol++; after fcol=FEATURE_SIZE-1 -> WAIT.
- WAIT: i_en_prcs_new_wcoln -> wcol<WEIGHT_SIZE-1: wcol++, LOADW; else channel end. i_en_fifo_loop -> LOADW with same wcol (replay).
- Channel end: chan<N_CHANNEL-1: chan++, wcnt=fcnt=0, FILL. Else o_done pulse, chan=0, counts cleared, FILL.
- i_en_prcs_new_chnl in LOADW/STREAM/WAIT: abort remainder, take channel-end path next cycle. Ignored in FILL.
- Priority within one cycle: new_chnl > new_wcoln > fifo_loop; lower ones dropped.
- Requests arriving in LOADW/STREAM other than new_chnl are ignored (not queued).
- Buffers are not cleared; only counts reset. Replay reads unchanged wbuf.

## Timing
- All outputs registered. Reset (async): state FILL, all counters 0, o_enable_loadw/o_enable_loadip/o_done/o_busy 0, data buses 0, o_w_ready/o_f_ready 1 one cycle after release (comb. from state, so 1 during reset too once state is FILL).
- Last upload accepted at edge T -> o_enable_loadw high cycle T+1 -> o_enable_loadip high T+2 .. T+1+FEATURE_SIZE.
- Request sampled at edge R in WAIT -> o_enable_loadw at R+1.
- Data buses hold last driven value when strobes low.
- o_busy=1 in LOADW/STREAM/WAIT; o_done coincident with transition to FILL.
- Reset mid-STREAM: strobes drop immediately, partial column discarded.

## Structure
- Shared package: state enum, CHAN_W = $clog2(N_CHANNEL), column width helpers.
- One sub-module natural: deconv_col_buf (parametric depth/width register array, write-indexed, read-indexed), instantiated twice for weights and features.

## Test plan
- Reset then upload 5 weight cols (0x01..0x05 replicated) and 8 feature cols -> loadw pulse with col 0x0101010101, then 8 loadip cycles with fbuf[0..7] in order.
- Pulse new_wcoln 4 times in WAIT -> wcol 1..4 presented; 5th pulse, N_CHANNEL=2 -> o_chan_idx=1, ready high, FILL.
- Pulse fifo_loop in WAIT -> same weight column re-loaded, 8 more loadip cycles, wcol unchanged.
- new_chnl during STREAM fcol=3 -> strobes stop next cycle, chan advances; on last channel o_done pulses once.
- new_wcoln and fifo_loop same cycle -> only advance occurs; assert i_rst mid-STREAM -> all strobes 0 same cycle, state FILL, counters 0.
